// File: rtl/regfile_write_buffer.sv
// Register-file write front end: merges pipeline writeback (port A) with a
// buffered mul/div result stream (port B), cancels overtaken writes, and forwards pending data.
module regfile_write_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_a_valid,
    input  logic [AW-1:0]            i_a_addr,
    input  logic [DW-1:0]            i_a_data,
    input  logic                     i_b_valid,
    output logic                     o_b_ready,
    input  logic [AW-1:0]            i_b_addr,
    input  logic [DW-1:0]            i_b_data,
    output logic                     o_we3,
    output logic [AW-1:0]            o_wa3,
    output logic [DW-1:0]            o_wd3,
    input  logic [AW-1:0]            i_fa1,
    input  logic [AW-1:0]            i_fa2,
    output logic                     o_fhit1,
    output logic                     o_fhit2,
    output logic [DW-1:0]            o_fdat1,
    output logic [DW-1:0]            o_fdat2,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]  r_head;
    logic [PW-1:0]  r_tail;
    logic [CW-1:0]  r_count;
    logic [DEPTH-1:0] r_valid;
    logic [AW-1:0]  r_addr [DEPTH];
    logic [DW-1:0]  r_data [DEPTH];

    logic           r_we3;
    logic [AW-1:0]  r_wa3;
    logic [DW-1:0]  r_wd3;

    logic           w_b_ready;
    logic           w_a_wr;
    logic           w_push;
    logic           w_pop;
    logic [DW:0]    w_look1;
    logic [DW:0]    w_look2;

    assign w_b_ready = (r_count < CW'(DEPTH));
    assign w_a_wr    = i_a_valid && (i_a_addr != '0);
    // Writes to r0 complete the handshake but never occupy a slot.
    assign w_push    = i_b_valid && w_b_ready && (i_b_addr != '0);
    assign w_pop     = !i_a_valid && (r_count != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_valid <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_a_wr && r_valid[i] && (r_addr[i] == i_a_addr)) begin
                    r_valid[i] <= 1'b0;
                end
            end
            if (w_pop) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + PW'(1);
            end
            // A same-cycle A write to the same register is younger, so the entry is born dead.
            if (w_push) begin
                r_valid[r_tail] <= !(w_a_wr && (i_b_addr == i_a_addr));
                r_addr[r_tail]  <= i_b_addr;
                r_data[r_tail]  <= i_b_data;
                r_tail          <= r_tail + PW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_we3 <= 1'b0;
            r_wa3 <= '0;
            r_wd3 <= '0;
        end else if (i_a_valid) begin
            r_we3 <= w_a_wr;
            if (w_a_wr) begin
                r_wa3 <= i_a_addr;
                r_wd3 <= i_a_data;
            end
        end else if (w_pop) begin
            r_we3 <= r_valid[r_head];
            if (r_valid[r_head]) begin
                r_wa3 <= r_addr[r_head];
                r_wd3 <= r_data[r_head];
            end
        end else begin
            r_we3 <= 1'b0;
        end
    end

    // Oldest-to-youngest scan so the youngest matching entry is the last to overwrite.
    function automatic logic [DW:0] lookup(input logic [AW-1:0] f);
        logic          hit;
        logic [DW-1:0] dat;
        logic [PW-1:0] idx;
        hit = 1'b0;
        dat = '0;
        if (f != '0) begin
            for (int k = 0; k < DEPTH; k++) begin
                idx = r_head + PW'(k);
                if ((CW'(k) < r_count) && r_valid[idx] && (r_addr[idx] == f)) begin
                    hit = 1'b1;
                    dat = r_data[idx];
                end
            end
            if (!hit && r_we3 && (r_wa3 == f)) begin
                hit = 1'b1;
                dat = r_wd3;
            end
        end
        return {hit, dat};
    endfunction

    always_comb begin
        w_look1 = lookup(i_fa1);
        w_look2 = lookup(i_fa2);
    end

    assign o_b_ready = w_b_ready;
    assign o_we3     = r_we3;
    assign o_wa3     = r_wa3;
    assign o_wd3     = r_wd3;
    assign o_fhit1   = w_look1[DW];
    assign o_fdat1   = w_look1[DW-1:0];
    assign o_fhit2   = w_look2[DW];
    assign o_fdat2   = w_look2[DW-1:0];
    assign o_count   = r_count;

endmodule

// File: doc/regfile_write_buffer.md
Name: regfile_write_buffer

Overview:
Write-side front end for the three-ported register file. It merges two writeback producers into the single write port (we3/wa3/wd3):
- the in-order pipeline writeback stage (port A, always accepted);
- the multicycle mul/div unit (port B, valid/ready, buffered in a small FIFO).

It cancels stale buffered writes that a younger pipeline write overtakes. It also provides a forwarding lookup so decode sees pending values before they reach the register file.

Parameters:
DEPTH, 4, FIFO entries for port B; power of 2, 2..16
AW, 5, register address width
DW, 32, data width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
a_valid  in  1  pipeline writeback valid
a_addr  in  AW  pipeline destination register
a_data  in  DW  pipeline writeback data
b_valid  in  1  mul/div result valid
b_ready  out  1  buffer can accept port B
b_addr  in  AW  mul/div destination register
b_data  in  DW  mul/div result
we3  out  1  register file write enable (registered)
wa3  out  AW  register file write address (registered)
wd3  out  DW  register file write data (registered)
fa1, fa2  in  AW  forwarding lookup addresses (decode ra1/ra2)
fhit1, fhit2  out  1  pending write exists for fa1/fa2 (combinational)
fdat1, fdat2  out  DW  youngest pending data for fa1/fa2 (combinational)
count  out  clog2(DEPTH)+1  live FIFO occupancy (valid and invalidated slots)

Behaviour:
- Reset (synchronous):
  - we3=0, wa3=0, wd3=0.
  - FIFO empty: head=tail=count=0, all entry valid bits cleared.
  - b_ready=1.
  - Any in-flight B entries are discarded. A/B inputs in the reset cycle are ignored.
- Output stage: a single register. Latency is 1 cycle from an accepted write to we3/wa3/wd3. The register file commits it on the following edge.
- Output-stage selection each cycle, in priority order:
  - a_valid=1 and a_addr!=0: output loads {1, a_addr, a_data}.
  - a_valid=1 and a_addr==0: output loads we3=0. The slot is consumed and no FIFO pop occurs.
  - a_valid=0 and count>0: pop the head entry. If the head is valid, load {1, addr, data}; if invalidated, load we3=0 (slot burned).
  - Otherwise: we3=0. wa3/wd3 hold their previous values.
- Port A is never back-pressured. Port B drains only in cycles with a_valid=0; starvation under continuous A traffic is acceptable.
- Port B handshake:
  - b_ready = (count < DEPTH), computed from registered count only. A same-cycle pop does not raise b_ready.
  - A transfer occurs when b_valid && b_ready. The entry is written at tail with valid=1, and tail increments modulo DEPTH.
  - b_addr==0 transfers complete (handshake honoured) but nothing is stored.
- Simultaneous push and pop: count is unchanged; head and tail both advance.
- Pointer wrap: head and tail wrap at DEPTH independently. Full is count==DEPTH and empty is count==0, with no pointer-equality ambiguity.
- Ordering and kill:
  - A port-A write is younger than every buffered B entry and than any B entry accepted in the same cycle.
  - When a_valid && a_addr!=0, every FIFO entry with valid=1 and addr==a_addr has valid cleared at that edge.
  - A B entry pushed in the same cycle with b_addr==a_addr is stored with valid=0.
  - Invalidated entries keep their slot and drain as we3=0.
- Forwarding lookup (each port independent, purely combinational):
  - f==0: hit=0, data=0.
  - Otherwise, search valid FIFO entries youngest to oldest (tail-1 down to head). The first match wins.
  - If no FIFO match and we3=1 with wa3==f: hit=1, data=wd3.
  - Otherwise hit=0, data=0.
  - The lookup does not include same-cycle a_*/b_* inputs; decode stalls or bypasses those itself.
- No overflow is possible: B is gated by b_ready. No underflow is possible: a pop occurs only when count>0.

Test Plan:
1. Reset, then a_valid=1, a_addr=5, a_data=0x11 for 1 cycle -> next cycle we3=1, wa3=5, wd3=0x11; following cycle we3=0.
2. Push B: (3,0xAA), (4,0xBB), (6,0xCC), (7,0xDD) with a_valid held 1, a_addr=0 -> after 4th push count=4, b_ready=0. Drop a_valid -> we3 writes 3,4,6,7 on 4 consecutive cycles; b_ready=1 the cycle after the first pop.
3. Buffer B (9,0x01), then a_valid write (9,0x02) -> B entry invalidated. Drain -> wa3=9/0x02 once, then one we3=0 burned slot. Register 9 ends at 0x02.
4. Same cycle b_valid (8,0x55) and a_valid (8,0x66) -> we3=1, wa3=8, wd3=0x66. Later drain of the B slot gives we3=0; count returns to 0.
5. Buffer B (10,0x1), (10,0x2) with a_valid=1, a_addr=0; fa1=10 -> fhit1=1, fdat1=0x2. fa2=0 -> fhit2=0. fa1=11 -> fhit1=0.
6. Fill 3 entries, assert reset mid-drain for 1 cycle -> count=0, we3=0, b_ready=1. No queued write appears after reset. A b_valid held during reset is not accepted.
